// File: rtl/dbg_scan_ctrl_if.sv
// Word stream from the debug scan sequencer to the host link.
// Carries address/data pairs over a valid/ready handshake.
interface dbg_scan_ctrl_if;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_addr;
  logic [31:0] out_data;

  modport master (output out_valid, output out_addr, output out_data, input out_ready);
  modport slave  (input out_valid, input out_addr, input out_data, output out_ready);
endinterface

// File: rtl/dbg_scan_ctrl.sv
// Debug-bus scan sequencer: walks an address range, captures chk_data, streams pairs out.
// Optional macro DBG_SCAN_CHKSUM_EN appends a 32-bit checksum word at address 0xFFFF.
module dbg_scan_ctrl #(
  parameter int SETTLE = 1,
  parameter int CNT_W  = 9
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             start,
  input  logic             abort,
  input  logic [15:0]      base_addr,
  input  logic [CNT_W-1:0] count,
  input  logic [15:0]      manual_addr,
  output logic [15:0]      chk_addr,
  input  logic [31:0]      chk_data,
  dbg_scan_ctrl_if.master  out_if,
  output logic             busy,
  output logic             done
);

`ifdef DBG_SCAN_CHKSUM_EN
  typedef enum logic [1:0] {IDLE, WAIT, OUT, LAST} state_t;
`else
  typedef enum logic [1:0] {IDLE, WAIT, OUT} state_t;
`endif

  localparam logic [3:0] SETTLE_CNT = 4'(SETTLE);

  state_t           state, state_n;
  logic [3:0]       settle_cnt, settle_n;
  logic [CNT_W-1:0] idx, idx_n;
  logic [CNT_W-1:0] cnt_q, cnt_n;
  logic [15:0]      chk_addr_n;
  logic             out_valid_n;
  logic [15:0]      out_addr_n;
  logic [31:0]      out_data_n;
  logic             busy_n;
  logic             done_n;
  logic             hs;
`ifdef DBG_SCAN_CHKSUM_EN
  logic [31:0]      acc, acc_n;
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state            <= IDLE;
      settle_cnt       <= '0;
      idx              <= '0;
      cnt_q            <= '0;
      chk_addr         <= '0;
      out_if.out_valid <= 1'b0;
      out_if.out_addr  <= '0;
      out_if.out_data  <= '0;
      busy             <= 1'b0;
      done             <= 1'b0;
`ifdef DBG_SCAN_CHKSUM_EN
      acc              <= '0;
`endif
    end else begin
      state            <= state_n;
      settle_cnt       <= settle_n;
      idx              <= idx_n;
      cnt_q            <= cnt_n;
      chk_addr         <= chk_addr_n;
      out_if.out_valid <= out_valid_n;
      out_if.out_addr  <= out_addr_n;
      out_if.out_data  <= out_data_n;
      busy             <= busy_n;
      done             <= done_n;
`ifdef DBG_SCAN_CHKSUM_EN
      acc              <= acc_n;
`endif
    end
  end

  // Every output is computed here and registered above, so abort simply overrides the state work.
  always_comb begin
    state_n     = state;
    settle_n    = settle_cnt;
    idx_n       = idx;
    cnt_n       = cnt_q;
    chk_addr_n  = chk_addr;
    out_valid_n = out_if.out_valid;
    out_addr_n  = out_if.out_addr;
    out_data_n  = out_if.out_data;
    done_n      = 1'b0;
`ifdef DBG_SCAN_CHKSUM_EN
    acc_n       = acc;
`endif
    hs          = out_if.out_valid & out_if.out_ready;

    if (abort && state != IDLE) begin
      state_n     = IDLE;
      out_valid_n = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          chk_addr_n = manual_addr;
          if (start) begin
            if (count != '0) begin
              state_n    = WAIT;
              chk_addr_n = base_addr;
              cnt_n      = count;
              idx_n      = '0;
              settle_n   = '0;
`ifdef DBG_SCAN_CHKSUM_EN
              acc_n      = '0;
`endif
            end else begin
              done_n = 1'b1;
            end
          end
        end
        WAIT: begin
          if (settle_cnt == SETTLE_CNT) begin
            out_data_n  = chk_data;
            out_addr_n  = chk_addr;
            out_valid_n = 1'b1;
            state_n     = OUT;
          end else begin
            settle_n = settle_cnt + 4'd1;
          end
        end
        OUT: begin
          if (hs) begin
            out_valid_n = 1'b0;
`ifdef DBG_SCAN_CHKSUM_EN
            acc_n = acc + out_if.out_data;
`endif
            if (idx == cnt_q - CNT_W'(1)) begin
`ifdef DBG_SCAN_CHKSUM_EN
              out_valid_n = 1'b1;
              out_addr_n  = 16'hFFFF;
              out_data_n  = acc + out_if.out_data;
              state_n     = LAST;
`else
              done_n  = 1'b1;
              state_n = IDLE;
`endif
            end else begin
              idx_n      = idx + CNT_W'(1);
              chk_addr_n = chk_addr + 16'd1;
              settle_n   = '0;
              state_n    = WAIT;
            end
          end
        end
`ifdef DBG_SCAN_CHKSUM_EN
        LAST: begin
          if (hs) begin
            out_valid_n = 1'b0;
            done_n      = 1'b1;
            state_n     = IDLE;
          end
        end
`endif
        default: state_n = IDLE;
      endcase
    end

    busy_n = (state_n != IDLE);
  end

endmodule

// File: tb/tb_dbg_scan_ctrl.sv
// Randomized self-checking bench for dbg_scan_ctrl against a list-based scan model.
// Honours DBG_SCAN_CHKSUM_EN by appending the expected checksum word.
module tb_dbg_scan_ctrl;
  localparam int CNT_W = 9;

  logic             clk = 1'b0;
  logic             rstn;
  logic             start;
  logic             abort;
  logic [15:0]      base_addr;
  logic [CNT_W-1:0] count;
  logic [15:0]      manual_addr;
  logic [15:0]      chk_addr;
  logic [31:0]      chk_data;
  logic             busy;
  logic             done;

  dbg_scan_ctrl_if sif ();

  dbg_scan_ctrl #(.SETTLE(1), .CNT_W(CNT_W)) dut (
    .clk(clk), .rstn(rstn), .start(start), .abort(abort),
    .base_addr(base_addr), .count(count), .manual_addr(manual_addr),
    .chk_addr(chk_addr), .chk_data(chk_data), .out_if(sif.master),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Debug-bus contents: an affine pattern, optionally overridden by a three-entry table at 0x1000.
  logic [15:0] data_hi;
  logic [31:0] data_add;
  logic        use_table;
  logic [31:0] table_data [3];
  logic [15:0] tbl_idx;
  assign tbl_idx  = chk_addr - 16'h1000;
  assign chk_data = (use_table && tbl_idx < 16'd3) ? table_data[tbl_idx[1:0]]
                                                  : ({data_hi, chk_addr} + data_add);

  int          ready_mode;
  logic        rand_ready;
  logic        force_ready;
  assign sif.out_ready = (ready_mode == 0) ? 1'b1 : (ready_mode == 1) ? rand_ready : force_ready;

  int          checks = 0;
  int          errors = 0;
  int          done_cnt;
  logic [15:0] got_addr [$];
  logic [31:0] got_data [$];
  logic [15:0] exp_addr [$];
  logic [31:0] exp_data [$];

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] dataOf(input logic [15:0] a);
    if (use_table && a >= 16'h1000 && a <= 16'h1002)
      return table_data[a - 16'h1000];
    return {data_hi, 16'h0000} + {16'h0000, a} + data_add;
  endfunction

  function automatic void buildExpected(input logic [15:0] b, input int c);
    logic [31:0] sum;
    logic [15:0] a;
    exp_addr.delete();
    exp_data.delete();
    sum = 0;
    for (int i = 0; i < c; i++) begin
      a = 16'((32'(b) + i) % 65536);
      exp_addr.push_back(a);
      exp_data.push_back(dataOf(a));
      sum = sum + dataOf(a);
    end
`ifdef DBG_SCAN_CHKSUM_EN
    if (c != 0) begin
      exp_addr.push_back(16'hFFFF);
      exp_data.push_back(sum);
    end
`endif
  endfunction

  // Observe the stream just after each falling edge; ready is stable there until the next rising edge.
  always begin
    @(negedge clk);
    rand_ready = 1'($urandom_range(0, 1));
    #1;
    if (rstn) begin
      if (sif.out_valid && sif.out_ready && !abort) begin
        got_addr.push_back(sif.out_addr);
        got_data.push_back(sif.out_data);
      end
      if (done) begin
        done_cnt++;
        checkOutput("done_excl_valid", sif.out_valid, 0);
      end
    end
  end

  task automatic applyStimulus(input logic [15:0] b, input logic [CNT_W-1:0] c);
    @(negedge clk);
    base_addr = b;
    count     = c;
    start     = 1'b1;
    @(negedge clk);
    start     = 1'b0;
    base_addr = 16'($urandom);
    count     = CNT_W'($urandom);
  endtask

  task automatic startScan(input logic [15:0] b, input logic [CNT_W-1:0] c);
    got_addr.delete();
    got_data.delete();
    done_cnt = 0;
    buildExpected(b, int'(c));
    applyStimulus(b, c);
  endtask

  task automatic finishScan(input string tag);
    int n = 0;
    while (done_cnt == 0 && n < 4000) begin
      @(negedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
    checkOutput({tag, "_done"}, done_cnt, 1);
    checkOutput({tag, "_busy"}, busy, 0);
    checkOutput({tag, "_nwords"}, got_addr.size(), exp_addr.size());
    for (int i = 0; i < exp_addr.size(); i++) begin
      if (i < got_addr.size()) begin
        checkOutput($sformatf("%s_addr%0d", tag, i), got_addr[i], exp_addr[i]);
        checkOutput($sformatf("%s_data%0d", tag, i), got_data[i], exp_data[i]);
      end
    end
  endtask

  task automatic runScan(input logic [15:0] b, input logic [CNT_W-1:0] c, input string tag);
    startScan(b, c);
    finishScan(tag);
  endtask

  task automatic waitValid(input string tag);
    int n = 0;
    while (!sif.out_valid && n < 200) begin
      @(negedge clk);
      n++;
    end
    checkOutput({tag, "_valid"}, sif.out_valid, 1);
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_chk_addr"}, chk_addr, 0);
    checkOutput({tag, "_out_addr"}, sif.out_addr, 0);
    checkOutput({tag, "_out_data"}, sif.out_data, 0);
    checkOutput({tag, "_out_valid"}, sif.out_valid, 0);
    checkOutput({tag, "_busy"}, busy, 0);
    checkOutput({tag, "_done"}, done, 0);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL global_timeout: got no finish, expected finish");
    $fatal(1, "[TB] simulation time limit");
  end

  initial begin
    rstn        = 1'b0;
    start       = 1'b0;
    abort       = 1'b0;
    base_addr   = '0;
    count       = '0;
    manual_addr = 16'h0777;
    data_hi     = 16'hA000;
    data_add    = '0;
    use_table   = 1'b0;
    table_data[0] = 32'h0000_0001;
    table_data[1] = 32'h0000_0002;
    table_data[2] = 32'hFFFF_FFFF;
    ready_mode  = 0;
    force_ready = 1'b0;
    done_cnt    = 0;

    repeat (3) @(negedge clk);
    checkResetOutputs("rst");
    rstn = 1'b1;

    @(negedge clk);
    manual_addr = 16'h1005;
    @(negedge clk);
    checkOutput("manual_pass", chk_addr, 16'h1005);

    $display("[TB] basic scan with first-word latency");
    startScan(16'h0000, 4);
    checkOutput("lat_k1_valid", sif.out_valid, 0);
    checkOutput("lat_k1_busy", busy, 1);
    @(negedge clk);
    checkOutput("lat_k2_valid", sif.out_valid, 0);
    @(negedge clk);
    checkOutput("lat_k3_valid", sif.out_valid, 1);
    finishScan("basic");

    $display("[TB] backpressure");
    data_hi    = 16'($urandom);
    data_add   = $urandom;
    ready_mode = 2;
    force_ready = 1'b0;
    startScan(16'h2000, 2);
    waitValid("bp");
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput($sformatf("bp_hold_addr%0d", i), sif.out_addr, 16'h2000);
      checkOutput($sformatf("bp_hold_data%0d", i), sif.out_data, dataOf(16'h2000));
      checkOutput($sformatf("bp_hold_chk%0d", i), chk_addr, 16'h2000);
    end
    force_ready = 1'b1;
    finishScan("bp");

    $display("[TB] address wrap");
    ready_mode = 1;
    runScan(16'hFFFE, 3, "wrap");

    $display("[TB] zero count");
    startScan(16'h1234, 0);
    checkOutput("zero_busy", busy, 0);
    checkOutput("zero_valid", sif.out_valid, 0);
    finishScan("zero");

    $display("[TB] abort mid-stream");
    ready_mode  = 2;
    force_ready = 1'b0;
    manual_addr = 16'h4242;
    startScan(16'h5000, 4);
    base_addr = 16'h9999;
    count     = 2;
    start     = 1'b1;
    @(negedge clk);
    start     = 1'b0;
    waitValid("ab0");
    checkOutput("ab0_addr", sif.out_addr, 16'h5000);
    force_ready = 1'b1;
    @(negedge clk);
    force_ready = 1'b0;
    waitValid("ab1");
    checkOutput("ab1_addr", sif.out_addr, 16'h5001);
    abort       = 1'b1;
    force_ready = 1'b1;
    @(negedge clk);
    abort       = 1'b0;
    force_ready = 1'b0;
    checkOutput("ab_valid_drop", sif.out_valid, 0);
    checkOutput("ab_busy_drop", busy, 0);
    @(negedge clk);
    checkOutput("ab_manual", chk_addr, 16'h4242);
    repeat (4) @(negedge clk);
    checkOutput("ab_no_done", done_cnt, 0);
    checkOutput("ab_nwords", got_addr.size(), 1);
    checkOutput("ab_w0", (got_addr.size() > 0) ? got_addr[0] : 16'h0000, 16'h5000);
    ready_mode = 1;
    runScan(16'h6000, 4, "after_abort");

    $display("[TB] random scans");
    for (int r = 0; r < 8; r++) begin
      data_hi    = 16'($urandom);
      data_add   = $urandom;
      ready_mode = $urandom_range(0, 1);
      runScan(16'($urandom), CNT_W'($urandom_range(1, 10)), $sformatf("rnd%0d", r));
    end

`ifdef DBG_SCAN_CHKSUM_EN
    $display("[TB] checksum word");
    use_table  = 1'b1;
    ready_mode = 0;
    runScan(16'h1000, 3, "cks");
    checkOutput("cks_last_addr", (got_addr.size() == 4) ? got_addr[3] : 16'h0000, 16'hFFFF);
    checkOutput("cks_last_data", (got_data.size() == 4) ? got_data[3] : 32'h0, 32'h0000_0002);
    use_table  = 1'b0;
`endif

    $display("[TB] reset mid-scan");
    ready_mode = 2;
    force_ready = 1'b0;
    startScan(16'h3000, 8);
    repeat (3) @(negedge clk);
    rstn = 1'b0;
    #1;
    checkResetOutputs("midrst");
    @(negedge clk);
    rstn = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("midrst_no_done", done_cnt, 0);
    ready_mode = 1;
    runScan(16'h7000, 5, "post_rst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
